// File: rtl/net_pkg.sv
// Shared word/address widths, neighbor-table memory map and scan FSM state encoding.
package net_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int ADDR_WIDTH = 11;
  localparam int MAX_NBRS   = 18;
  localparam int IDX_WIDTH  = 5;

  localparam logic [ADDR_WIDTH-1:0] NBR_CNT_ADDR  = 11'h58E;
  localparam logic [ADDR_WIDTH-1:0] NBR_BASE      = 11'h590;
  localparam logic [ADDR_WIDTH-1:0] LIST_BASE     = 11'h668;
  localparam logic [ADDR_WIDTH-1:0] LIST_CNT_ADDR = 11'h68C;
  localparam logic [WORD_WIDTH-1:0] NO_HOP        = 16'd65;

  typedef enum logic [1:0] {
    FLD_ID  = 2'd0,
    FLD_HOP = 2'd1,
    FLD_VAL = 2'd2
  } fld_e;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CNT, S_RD_ID, S_RD_HOP, S_RD_VAL,
    S_EVAL, S_WR_LIST, S_NEXT, S_WR_CNT, S_WR_END
  } scan_state_e;

  // Byte offset of a field inside one 6-byte table entry.
  function automatic logic [ADDR_WIDTH-1:0] field_offset(input fld_e f);
    return ADDR_WIDTH'({f, 1'b0});
  endfunction
endpackage

// File: rtl/nbr_addr_gen.sv
// Combinational byte-address generator for neighbor-table fields and better-neighbor list slots.
module nbr_addr_gen
  import net_pkg::*;
(
  input  logic [IDX_WIDTH-1:0]  i_k,
  input  fld_e                  i_field,
  input  logic [IDX_WIDTH-1:0]  i_j,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr,
  output logic [ADDR_WIDTH-1:0] o_list_addr
);
  logic [ADDR_WIDTH-1:0] w_k;
  logic [ADDR_WIDTH-1:0] w_j;

  assign w_k         = ADDR_WIDTH'(i_k);
  assign w_j         = ADDR_WIDTH'(i_j);
  assign o_tbl_addr  = NBR_BASE + (w_k * ADDR_WIDTH'(6)) + field_offset(i_field);
  assign o_list_addr = LIST_BASE + (w_j << 1);
endmodule

// File: rtl/neighbor_scan.sv
// Walks the neighbor table, tracks the best advertised neighbor and writes the better-neighbor list.
// Optional macro NBR_SCAN_LOOP_FILTER_EN: skip entries whose hop is this node (routing-loop filter).
module neighbor_scan
  import net_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start_scan,
  input  logic [WORD_WIDTH-1:0] mybest,
  input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] bestvalue,
  output logic [WORD_WIDTH-1:0] besthop,
  output logic [WORD_WIDTH-1:0] bestneighborID,
  output logic [WORD_WIDTH-1:0] betterNeighborCount,
  output logic                  busy,
  output logic                  done_scan
);
  scan_state_e           r_state;
  logic [IDX_WIDTH-1:0]  r_k, r_n, r_j;
  logic [WORD_WIDTH-1:0] r_id, r_hop, r_val;
  logic [WORD_WIDTH-1:0] r_best_val, r_best_hop, r_best_id, r_count, r_data_out;
  logic [ADDR_WIDTH-1:0] r_address;
  logic                  r_have_best, r_wr_en, r_busy, r_done;

  logic [IDX_WIDTH-1:0]  w_k_sel, w_n;
  fld_e                  w_field;
  logic [ADDR_WIDTH-1:0] w_tbl_addr, w_list_addr;
  logic                  w_skip;

  assign w_k_sel = (r_state == S_NEXT) ? r_k + IDX_WIDTH'(1) : r_k;
  assign w_n     = (data_in > WORD_WIDTH'(MAX_NBRS)) ? IDX_WIDTH'(MAX_NBRS)
                                                     : data_in[IDX_WIDTH-1:0];

  always_comb begin
    w_field = FLD_ID;
    case (r_state)
      S_RD_ID:  w_field = FLD_HOP;
      S_RD_HOP: w_field = FLD_VAL;
      default:  w_field = FLD_ID;
    endcase
  end

`ifdef NBR_SCAN_LOOP_FILTER_EN
  assign w_skip = (r_hop == MY_NODE_ID);
`else
  assign w_skip = 1'b0;
`endif

  nbr_addr_gen u_addr_gen (
    .i_k         (w_k_sel),
    .i_field     (w_field),
    .i_j         (r_j),
    .o_tbl_addr  (w_tbl_addr),
    .o_list_addr (w_list_addr)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_n         <= '0;
      r_j         <= '0;
      r_id        <= '0;
      r_hop       <= '0;
      r_val       <= '0;
      r_best_val  <= '0;
      r_best_hop  <= NO_HOP;
      r_best_id   <= '0;
      r_have_best <= 1'b0;
      r_count     <= '0;
      r_address   <= '0;
      r_data_out  <= '0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start_scan) begin
          r_best_val  <= '0;
          r_best_hop  <= NO_HOP;
          r_best_id   <= '0;
          r_have_best <= 1'b0;
          r_count     <= '0;
          r_k         <= '0;
          r_j         <= '0;
          r_address   <= NBR_CNT_ADDR;
          r_busy      <= 1'b1;
          r_state     <= S_RD_CNT;
        end
        S_RD_CNT: begin
          r_n <= w_n;
          r_k <= '0;
          r_j <= '0;
          if (w_n == '0) begin
            r_state <= S_WR_CNT;
          end else begin
            r_address <= w_tbl_addr;
            r_state   <= S_RD_ID;
          end
        end
        S_RD_ID: begin
          r_id      <= data_in;
          r_address <= w_tbl_addr;
          r_state   <= S_RD_HOP;
        end
        S_RD_HOP: begin
          r_hop     <= data_in;
          r_address <= w_tbl_addr;
          r_state   <= S_RD_VAL;
        end
        S_RD_VAL: begin
          r_val   <= data_in;
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          r_state <= S_NEXT;
          if (!w_skip) begin
            // Strict compare keeps the lowest-index entry on ties.
            if (!r_have_best || (r_val > r_best_val)) begin
              r_have_best <= 1'b1;
              r_best_val  <= r_val;
              r_best_hop  <= r_hop;
              r_best_id   <= r_id;
            end
            if (r_val > mybest) begin
              r_address  <= w_list_addr;
              r_data_out <= r_id;
              r_wr_en    <= 1'b1;
              r_state    <= S_WR_LIST;
            end
          end
        end
        S_WR_LIST: begin
          r_wr_en <= 1'b0;
          r_j     <= r_j + IDX_WIDTH'(1);
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          r_k <= r_k + IDX_WIDTH'(1);
          if ((r_k + IDX_WIDTH'(1)) == r_n) begin
            r_state <= S_WR_CNT;
          end else begin
            r_address <= w_tbl_addr;
            r_state   <= S_RD_ID;
          end
        end
        S_WR_CNT: begin
          r_address  <= LIST_CNT_ADDR;
          r_data_out <= WORD_WIDTH'(r_j);
          r_wr_en    <= 1'b1;
          r_state    <= S_WR_END;
        end
        S_WR_END: begin
          r_wr_en <= 1'b0;
          r_count <= WORD_WIDTH'(r_j);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Until an entry has been accepted the best ID follows the node's own ID.
  assign bestneighborID      = r_have_best ? r_best_id : MY_NODE_ID;
  assign bestvalue           = r_best_val;
  assign besthop             = r_best_hop;
  assign betterNeighborCount = r_count;
  assign address             = r_address;
  assign data_out            = r_data_out;
  assign wr_en               = r_wr_en;
  assign busy                = r_busy;
  assign done_scan           = r_done;
endmodule

// File: tb/tb_neighbor_scan.sv
// Self-checking bench for neighbor_scan: memory model, directed and random scans against a reference model.
module tb_neighbor_scan;
  import net_pkg::*;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        start_scan = 1'b0;
  logic [15:0] mybest = 16'h0030;
  logic [15:0] MY_NODE_ID = 16'h0077;
  logic [15:0] data_in;
  logic [10:0] address;
  logic [15:0] data_out, bestvalue, besthop, bestneighborID, betterNeighborCount;
  logic        wr_en, busy, done_scan;

  neighbor_scan dut (
    .clock(clock), .rst(rst), .start_scan(start_scan), .mybest(mybest),
    .MY_NODE_ID(MY_NODE_ID), .data_in(data_in), .address(address),
    .data_out(data_out), .wr_en(wr_en), .bestvalue(bestvalue), .besthop(besthop),
    .bestneighborID(bestneighborID), .betterNeighborCount(betterNeighborCount),
    .busy(busy), .done_scan(done_scan)
  );

  logic [15:0] mem [0:2047];
  logic [15:0] e_id [32];
  logic [15:0] e_hop [32];
  logic [15:0] e_val [32];
  logic [10:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  logic [10:0] max_rd;
  int          done_pulses;
  int          checks = 0;
  int          failures = 0;

  int          x_n, x_cyc;
  logic [15:0] x_bv, x_bh, x_bid;
  logic [15:0] x_list [$];

  assign data_in = mem[address];
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_en) begin
      mem[address] = data_out;
      wr_addr_q.push_back(address);
      wr_data_q.push_back(data_out);
    end
    if (done_scan) done_pulses++;
    if (busy && address < LIST_BASE && address > max_rd) max_rd = address;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_table(input int cnt);
    mem[NBR_CNT_ADDR] = 16'(cnt);
    for (int k = 0; k < 32; k++) begin
      mem[NBR_BASE + 11'(6 * k)]     = e_id[k];
      mem[NBR_BASE + 11'(6 * k + 2)] = e_hop[k];
      mem[NBR_BASE + 11'(6 * k + 4)] = e_val[k];
    end
    for (int a = LIST_BASE; a <= LIST_CNT_ADDR; a += 2) mem[a] = 16'hDEAD;
  endtask

  // Reference: best = first strictly-greater maximum, list = values above mybest in table order.
  task automatic model(input int cnt);
    bit have;
    have = 1'b0;
    x_list.delete();
    x_n   = (cnt > MAX_NBRS) ? MAX_NBRS : cnt;
    x_bv  = 16'd0;
    x_bh  = NO_HOP;
    x_bid = MY_NODE_ID;
    for (int k = 0; k < x_n; k++) begin
`ifdef NBR_SCAN_LOOP_FILTER_EN
      if (e_hop[k] == MY_NODE_ID) continue;
`endif
      if (!have || e_val[k] > x_bv) begin
        have  = 1'b1;
        x_bv  = e_val[k];
        x_bh  = e_hop[k];
        x_bid = e_id[k];
      end
      if (e_val[k] > mybest) x_list.push_back(e_id[k]);
    end
    x_cyc = 4 + 5 * x_n + x_list.size();
  endtask

  task automatic run_scan(input string tag, input int cnt, input int poke_cyc);
    int cyc;
    bit seen;
    load_table(cnt);
    model(cnt);
    wr_addr_q.delete();
    wr_data_q.delete();
    max_rd = '0;
    done_pulses = 0;
    @(negedge clock) start_scan = 1'b1;
    @(posedge clock);
    #1 start_scan = 1'b0;
    cyc = 1;
    seen = 1'b0;
    @(negedge clock);
    check_val({tag, "/busy_hi"}, busy, 1);
    while (!seen && cyc < 400) begin
      if (done_scan) seen = 1'b1;
      else begin
        start_scan = (cyc + 1 == poke_cyc);
        @(negedge clock);
        cyc++;
      end
    end
    start_scan = 1'b0;
    check_val({tag, "/done_seen"}, seen, 1);
    check_val({tag, "/cycles"}, cyc, x_cyc);
    check_val({tag, "/busy_lo"}, busy, 0);
    check_val({tag, "/bestvalue"}, bestvalue, x_bv);
    check_val({tag, "/besthop"}, besthop, x_bh);
    check_val({tag, "/bestid"}, bestneighborID, x_bid);
    check_val({tag, "/count"}, betterNeighborCount, x_list.size());
    check_val({tag, "/mem_cnt"}, mem[LIST_CNT_ADDR], x_list.size());
    check_val({tag, "/max_rd"}, max_rd,
              (x_n == 0) ? NBR_CNT_ADDR : NBR_BASE + 11'(6 * (x_n - 1) + 4));
    check_val({tag, "/n_writes"}, wr_addr_q.size(), x_list.size() + 1);
    for (int i = 0; i < x_list.size() && i < wr_addr_q.size(); i++) begin
      check_val({tag, "/wr_addr"}, wr_addr_q[i], LIST_BASE + 11'(2 * i));
      check_val({tag, "/wr_data"}, wr_data_q[i], x_list[i]);
    end
    if (wr_addr_q.size() > 0)
      check_val({tag, "/last_wr"}, wr_addr_q[wr_addr_q.size() - 1], LIST_CNT_ADDR);
    @(negedge clock);
    @(negedge clock);
    check_val({tag, "/one_done"}, done_pulses, 1);
  endtask

  task automatic set_entry(input int k, input int id, input int hop, input int val);
    e_id[k]  = 16'(id);
    e_hop[k] = 16'(hop);
    e_val[k] = 16'(val);
  endtask

  initial begin
    int dcyc [$];
    bit hit;
    for (int k = 0; k < 32; k++) set_entry(k, 0, 0, 0);
    for (int a = 0; a < 2048; a++) mem[a] = '0;

    #12;
    check_val("rst/address", address, 0);
    check_val("rst/wr_en", wr_en, 0);
    check_val("rst/busy", busy, 0);
    check_val("rst/done", done_scan, 0);
    check_val("rst/bestvalue", bestvalue, 0);
    check_val("rst/besthop", besthop, NO_HOP);
    check_val("rst/bestid", bestneighborID, MY_NODE_ID);
    check_val("rst/count", betterNeighborCount, 0);
    @(negedge clock) rst = 1'b0;

    // Directed case from the data sheet: done 21 cycles after start.
    set_entry(0, 5, 7, 16'h40);
    set_entry(1, 6, 8, 16'h90);
    set_entry(2, 9, 9, 16'h20);
    mybest = 16'h30;
    run_scan("t1", 3, 0);
    check_val("t1/cyc21", x_cyc, 21);

    MY_NODE_ID = 16'h0123;
    run_scan("t2_empty", 0, 0);
    MY_NODE_ID = 16'h0077;

    for (int k = 0; k < 32; k++) set_entry(k, 100 + k, k, 16'h100 + k);
    run_scan("t3_clamp", 25, 0);

    for (int k = 0; k < 32; k++) set_entry(k, 0, 0, 0);
    set_entry(0, 11, 1, 16'h20);
    set_entry(1, 12, 2, 16'h50);
    set_entry(2, 13, 3, 16'h50);
    set_entry(3, 14, 4, 16'h10);
    run_scan("t4_tie", 4, 7);
    check_val("t4/lower_idx", bestneighborID, 12);

    // Asynchronous reset while a list write is in flight.
    for (int k = 0; k < 32; k++) set_entry(k, 40 + k, k, 16'h200);
    load_table(3);
    wr_addr_q.delete();
    @(negedge clock) start_scan = 1'b1;
    @(posedge clock);
    #1 start_scan = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clock);
      if (wr_en) hit = 1'b1;
    end
    check_val("t5/saw_wr", hit, 1);
    #1 rst = 1'b1;
    #1;
    check_val("t5/wr_en", wr_en, 0);
    check_val("t5/busy", busy, 0);
    check_val("t5/address", address, 0);
    check_val("t5/data_out", data_out, 0);
    check_val("t5/bestvalue", bestvalue, 0);
    check_val("t5/besthop", besthop, NO_HOP);
    check_val("t5/bestid", bestneighborID, MY_NODE_ID);
    @(negedge clock) rst = 1'b0;
    repeat (3) @(negedge clock);
    check_val("t5/no_more_wr", wr_addr_q.size(), 1);
    run_scan("t5_after", 3, 0);

    for (int k = 0; k < 32; k++) set_entry(k, 0, 0, 0);
    set_entry(0, 1, 3, 16'h20);
    set_entry(1, 2, 16'h77, 16'h300);
    set_entry(2, 3, 4, 16'h50);
    mybest = 16'h10;
    run_scan("t6_filter", 3, 0);
`ifdef NBR_SCAN_LOOP_FILTER_EN
    check_val("t6/bestid", bestneighborID, 3);
`else
    check_val("t6/bestid", bestneighborID, 2);
`endif

    // start_scan held high: back-to-back empty scans every 4 cycles.
    load_table(0);
    @(negedge clock) start_scan = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (done_scan) dcyc.push_back(c);
    end
    start_scan = 1'b0;
    check_val("hold/n_done", dcyc.size(), 5);
    if (dcyc.size() >= 2) begin
      check_val("hold/first", dcyc[0], 4);
      check_val("hold/second", dcyc[1], 8);
    end
    repeat (3) @(negedge clock);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 32; k++)
        set_entry(k, $urandom_range(1, 200), $urandom_range(16'h70, 16'h7A), $urandom_range(0, 16'h200));
      mybest = 16'($urandom_range(0, 16'h200));
      run_scan($sformatf("rnd%0d", r), $urandom_range(0, 22), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
